// File: rtl/signal_head_monitor.sv
// signal_head_monitor: registered lamp decoder and latched safety monitor for two signal heads
// Ports: CLK/reset (sync, active-high); L_A/L_B 3-bit light codes in;
//        LAMP_A/LAMP_B 5-bit lamp drive {red,yellow,green,left,right};
//        ERR latched fault; FAULT_CODE first fault (0 invalid,1 conflict,2 short yellow,3 mixed flash)
module signal_head_monitor #(
    parameter int BLINK_HALF = 4,
    parameter int MIN_YELLOW = 3
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] L_A,
    input  logic [2:0] L_B,
    output logic [4:0] LAMP_A,
    output logic [4:0] LAMP_B,
    output logic       ERR,
    output logic [1:0] FAULT_CODE
);
    logic [2:0] r_prev_a, r_prev_b, r_ycnt_a, r_ycnt_b;
    logic [3:0] r_cnt, w_cnt;
    logic       r_phase, r_act, w_phase, w_wrap;
    logic       w_f0, w_f1, w_f2, w_f3, w_fault, w_err, w_act, w_start;
    logic [1:0] w_code;

    function automatic logic is_flash(input logic [2:0] c);
        return c == 3'b000 || c == 3'b111;
    endfunction

    function automatic logic [4:0] lamp(input logic [2:0] c, input logic ph);
        return c == 3'b000 ? {1'b0, ph, 3'b000} :
               c == 3'b111 ? {ph, 4'b0000} :
               c == 3'b010 ? 5'b00001 :
               c == 3'b100 ? 5'b01000 :
               c == 3'b101 ? 5'b00010 :
               c == 3'b110 ? 5'b00100 : 5'b10000;
    endfunction

    always_comb begin
        w_f0 = L_A == 3'b001 || L_B == 3'b001;
        w_f1 = (L_A == 3'b110 && (L_B == 3'b110 || L_B == 3'b101)) ||
               (L_B == 3'b110 && L_A == 3'b101) || (L_A == 3'b101 && L_B == 3'b101);
        // leaving yellow early is a fault unless the head drops into flash
        w_f2 = (r_prev_a == 3'b100 && L_A != 3'b100 && !is_flash(L_A) && r_ycnt_a < 3'(MIN_YELLOW)) ||
               (r_prev_b == 3'b100 && L_B != 3'b100 && !is_flash(L_B) && r_ycnt_b < 3'(MIN_YELLOW));
        w_f3 = is_flash(L_A) ^ is_flash(L_B);
        w_fault = w_f0 | w_f1 | w_f2 | w_f3;
        w_code = w_f0 ? 2'd0 : w_f1 ? 2'd1 : w_f2 ? 2'd2 : 2'd3;
        w_err = ERR | w_fault;
        // a latched fault keeps the blinker running, so it counts as an episode
        w_act = is_flash(L_A) | is_flash(L_B) | w_err;
        w_start = w_act & ~r_act;
        w_cnt = w_start ? 4'd0 : r_cnt;
        w_phase = w_start ? 1'b1 : r_phase;
        w_wrap = w_cnt == 4'(BLINK_HALF - 1);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_prev_a   <= 3'b011;
            r_prev_b   <= 3'b011;
            r_ycnt_a   <= '0;
            r_ycnt_b   <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b1;
            r_act      <= 1'b0;
            ERR        <= 1'b0;
            FAULT_CODE <= '0;
            LAMP_A     <= '0;
            LAMP_B     <= '0;
        end else begin
            r_prev_a <= L_A;
            r_prev_b <= L_B;
            r_ycnt_a <= L_A != 3'b100 ? 3'd0 : r_ycnt_a == 3'd7 ? 3'd7 : r_ycnt_a + 3'd1;
            r_ycnt_b <= L_B != 3'b100 ? 3'd0 : r_ycnt_b == 3'd7 ? 3'd7 : r_ycnt_b + 3'd1;
            r_act    <= w_act;
            r_cnt    <= !w_act || w_wrap ? 4'd0 : w_cnt + 4'd1;
            r_phase  <= !w_act ? 1'b1 : w_wrap ? ~w_phase : w_phase;
            ERR      <= w_err;
            if (!ERR && w_fault)
                FAULT_CODE <= w_code;
            LAMP_A   <= w_err ? {w_phase, 4'b0000} : lamp(L_A, w_phase);
            LAMP_B   <= w_err ? {w_phase, 4'b0000} : lamp(L_B, w_phase);
        end
    end
endmodule

// File: tb/tb_signal_head_monitor.sv
// tb_signal_head_monitor: scoreboard bench with directed vectors for signal_head_monitor
module tb_signal_head_monitor;
    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] L_A = 3'b011, L_B = 3'b011;
    logic [4:0] LAMP_A, LAMP_B;
    logic       ERR;
    logic [1:0] FAULT_CODE;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic       e;
        logic [1:0] f;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, n_step = 0;
    bit   done = 1'b0;

    signal_head_monitor dut (
        .CLK(CLK), .reset(reset), .L_A(L_A), .L_B(L_B),
        .LAMP_A(LAMP_A), .LAMP_B(LAMP_B), .ERR(ERR), .FAULT_CODE(FAULT_CODE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            n_chk++;
            if (LAMP_A !== x.a || LAMP_B !== x.b || ERR !== x.e || FAULT_CODE !== x.f) begin
                n_fail++;
                $display("FAIL step%0d: got A=%b B=%b ERR=%b CODE=%0d, need A=%b B=%b ERR=%b CODE=%0d",
                         x.id, LAMP_A, LAMP_B, ERR, FAULT_CODE, x.a, x.b, x.e, x.f);
            end
        end
    end

    task automatic step(input logic [2:0] a, input logic [2:0] b, input bit rst,
                        input logic [4:0] ea, input logic [4:0] eb, input bit ee, input logic [1:0] ef);
        @(negedge CLK);
        L_A = a;
        L_B = b;
        reset = rst;
        q.push_back('{ea, eb, ee, ef, n_step});
        n_step++;
    endtask

    task automatic rst_step();
        step(3'b011, 3'b011, 1'b1, 5'b0, 5'b0, 1'b0, 2'd0);
    endtask

    initial begin
        rst_step();
        step(3'b110, 3'b011, 0, 5'b00100, 5'b10000, 0, 0);
        step(3'b010, 3'b101, 0, 5'b00001, 5'b00010, 0, 0);
        step(3'b101, 3'b010, 0, 5'b00010, 5'b00001, 0, 0);
        for (int i = 0; i < 3; i++) step(3'b100, 3'b011, 0, 5'b01000, 5'b10000, 0, 0);
        step(3'b011, 3'b011, 0, 5'b10000, 5'b10000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            logic [4:0] r;
            r = (i % 8) < 4 ? 5'b10000 : 5'b00000;
            step(3'b111, 3'b111, 0, r, r, 0, 0);
        end
        step(3'b011, 3'b011, 0, 5'b10000, 5'b10000, 0, 0);
        for (int i = 0; i < 5; i++) begin
            logic [4:0] y;
            y = i < 4 ? 5'b01000 : 5'b00000;
            step(3'b000, 3'b000, 0, y, y, 0, 0);
        end
        step(3'b011, 3'b011, 0, 5'b10000, 5'b10000, 0, 0);
        // short yellow on A, then blinking red while latched
        rst_step();
        for (int i = 0; i < 2; i++) step(3'b100, 3'b010, 0, 5'b01000, 5'b00001, 0, 0);
        step(3'b011, 3'b010, 0, 5'b10000, 5'b10000, 1, 2);
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r;
            r = i < 3 ? 5'b10000 : 5'b00000;
            step(3'b011, 3'b010, 0, r, r, 1, 2);
        end
        // green conflict, code must survive a later invalid code
        rst_step();
        step(3'b110, 3'b101, 0, 5'b10000, 5'b10000, 1, 1);
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r;
            r = i < 3 ? 5'b10000 : 5'b00000;
            step(3'b011, 3'b110, 0, r, r, 1, 1);
        end
        step(3'b001, 3'b011, 0, 5'b00000, 5'b00000, 1, 1);
        // invalid beats mixed flash, reset clears everything
        rst_step();
        step(3'b001, 3'b000, 0, 5'b10000, 5'b10000, 1, 0);
        rst_step();
        step(3'b111, 3'b011, 0, 5'b10000, 5'b10000, 1, 3);
        rst_step();
        step(3'b100, 3'b011, 0, 5'b01000, 5'b10000, 0, 0);
        step(3'b000, 3'b000, 0, 5'b01000, 5'b01000, 0, 0);
        step(3'b011, 3'b011, 0, 5'b10000, 5'b10000, 0, 0);
        // reset mid-yellow restarts the count
        rst_step();
        for (int i = 0; i < 2; i++) step(3'b100, 3'b011, 0, 5'b01000, 5'b10000, 0, 0);
        rst_step();
        step(3'b100, 3'b011, 0, 5'b01000, 5'b10000, 0, 0);
        step(3'b011, 3'b011, 0, 5'b10000, 5'b10000, 1, 2);
        rst_step();
        step(3'b101, 3'b101, 0, 5'b10000, 5'b10000, 1, 1);
        rst_step();
        step(3'b110, 3'b110, 0, 5'b10000, 5'b10000, 1, 1);
        rst_step();
        done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!done && budget < 2000) begin
            @(posedge CLK);
            budget++;
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
        #2;
        n_chk++;
        if (!done || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, need 0 (stimulus done=%0b)", q.size(), done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/signal_head_monitor.md
SIGNAL_HEAD_MONITOR -- requirements
Module: signal_head_monitor

Interface
REQ-001 Parameter BLINK_HALF, default 4: output cycles per half period (ON, then OFF) of flashing lamps; legal range 1..15.
REQ-002 Parameter MIN_YELLOW, default 3: minimum consecutive sampled cycles of Yellow before leaving Yellow; legal range 1..7.
REQ-003 CLK  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 L_A  input  3  approach A light code from the intersection controller.
REQ-006 L_B  input  3  approach B light code, same encoding as L_A.
REQ-007 LAMP_A  output  5  approach A lamp drive: [4] red, [3] yellow, [2] green, [1] left arrow, [0] right arrow.
REQ-008 LAMP_B  output  5  approach B lamp drive, same bit map as LAMP_A.
REQ-009 ERR  output  1  latched fault indication; feeds the controller ERR input.
REQ-010 FAULT_CODE  output  2  first fault detected: 0 invalid code, 1 green conflict, 2 short yellow, 3 mixed flash.

Function
REQ-011 Code map SHALL be: 000 flashing yellow, 001 invalid, 010 green right arrow, 011 red, 100 yellow, 101 green left arrow, 110 green, 111 flashing red.
REQ-012 Steady codes SHALL drive exactly one LAMP bit: red, yellow, green, left arrow or right arrow; invalid drives 5'b10000.
REQ-013 All outputs SHALL be registered; LAMP and ERR reflect inputs sampled one edge earlier (latency 1).
REQ-014 Flash episode: starts when at least one input is a flash code (000/111) and neither was in the previous cycle; blink counter SHALL clear and the phase SHALL be ON.
REQ-015 Flash codes SHALL drive the yellow or red bit ON for BLINK_HALF output cycles, then OFF for BLINK_HALF, repeating while the episode lasts.
REQ-016 Fault F0 (invalid): L_A or L_B equals 001.
REQ-017 Fault F1 (green conflict): one code is 110 and the other is 110 or 101, or both codes are 101; the 101/010 and 010/101 pairs are legal.
REQ-018 Fault F2 (short yellow): per approach, count consecutive cycles sampled as 100; fault when the code leaves 100 for a non-flash code with count < MIN_YELLOW; leaving to a flash code is exempt.
REQ-019 Fault F3 (mixed flash): exactly one of L_A, L_B is a flash code in the same cycle.
REQ-020 On any fault, ERR SHALL go 1 on the next edge and SHALL hold until reset.
REQ-021 FAULT_CODE SHALL capture the first fault; simultaneous faults resolve by priority F0 > F1 > F2 > F3; later faults SHALL NOT overwrite it.
REQ-022 While ERR=1, LAMP_A and LAMP_B SHALL both show flashing red (per REQ-015, phase running) regardless of inputs.
REQ-023 The fault-latch entry SHALL start a new flash episode if none was active.
REQ-024 Yellow counters SHALL saturate at 7.

Reset
REQ-025 With reset=1 at an edge: LAMP_A=LAMP_B=0, ERR=0, FAULT_CODE=0, blink counter=0, phase=ON, yellow counters=0, previous-code registers=011 (red).
REQ-026 Reset SHALL override fault detection in the same cycle; reset mid-yellow restarts yellow counting from 0.

Verification
REQ-027 Reset, then L_A=110, L_B=011 -> next cycle LAMP_A=00100, LAMP_B=10000, ERR=0.
REQ-028 L_A=L_B=111 for 12 cycles with BLINK_HALF=4 -> LAMP red bit 1,1,1,1,0,0,0,0,1,1,1,1 on both approaches.
REQ-029 L_A=110, L_B=101 -> next edge ERR=1, FAULT_CODE=1; later inputs 011/110 keep flashing red and FAULT_CODE=1.
REQ-030 L_A yellow for 2 cycles then 011, L_B=010 -> ERR=1, FAULT_CODE=2; yellow for 3 cycles then 011 -> no fault.
REQ-031 Same cycle L_A=001, L_B=000 -> FAULT_CODE=0 (priority over mixed flash); assert reset -> all outputs 0 next edge.
